cpu_if_fetch: RTL and testbench

Instruction fetch stage for the five-stage CPU. Owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents a registered instruction/PC pair to the decode stage. It honours the decode load-use stall and the global `cpu_stall`, and handles branch/jump redirects from execute. Redirects squash the wrong-path fetch while preserving the single branch delay slot.

---
 rtl/cpu_if_fetch.sv | 132 +++++++++++++
 tb/tb_cpu_if_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_if_fetch.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to instruction
// memory and presents a registered instruction/PC pair to decode.
module cpu_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stall,
  input  logic        c_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] p_inst,
  output logic [31:0] p_pc,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] p_inst_q, p_inst_d;
  logic [31:0] p_pc_q, p_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] flush_addr_q, flush_addr_d;

  logic advance;
  logic redirect;

  assign advance  = !cpu_stall && !c_stall;
  assign redirect = ex_redirect && !cpu_stall;

  // NOTE: every flop here is reset explicitly; the single-entry hold buffer is a
  // register, not a memory array, so it costs nothing to give it a known value.
  // NOTE: sequential state uses non-blocking assignments so all registers see
  // the pre-edge values of each other, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      p_inst_q     <= NOP;
      p_pc_q       <= 32'h0000_0000;
      buf_q        <= 32'h0000_0000;
      buf_pc_q     <= 32'h0000_0000;
      flush_addr_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      p_inst_q     <= p_inst_d;
      p_pc_q       <= p_pc_d;
      buf_q        <= buf_d;
      buf_pc_q     <= buf_pc_d;
      flush_addr_q <= flush_addr_d;
    end
  end

  // NOTE: every signal written below gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    p_inst_d     = p_inst_q;
    p_pc_d       = p_pc_q;
    buf_d        = buf_q;
    buf_pc_d     = buf_pc_q;
    flush_addr_d = flush_addr_q;

    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = ex_target;
          if (!c_stall) p_inst_d = NOP;
          // An outstanding wrong-path request must still be completed.
          if (!imem_ack) begin
            state_d      = S_FLUSH;
            flush_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (advance) begin
            p_inst_d = imem_rdata;
            p_pc_d   = pc_q;
          end else begin
            buf_d    = imem_rdata;
            buf_pc_d = pc_q;
            state_d  = S_HOLD;
          end
        end else if (advance) begin
          p_inst_d = NOP;
          p_pc_d   = pc_q;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = ex_target;
          state_d = S_FETCH;
          if (!c_stall) p_inst_d = NOP;
        end else if (advance) begin
          p_inst_d = buf_q;
          p_pc_d   = buf_pc_q;
          state_d  = S_FETCH;
        end
      end

      S_FLUSH: begin
        if (redirect) pc_d = ex_target;
        if (advance) p_inst_d = NOP;
        // The discarded ack closes the handshake even during a global freeze.
        if (imem_ack) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req   = !rst && (state_q != S_HOLD);
  assign imem_addr  = (state_q == S_FLUSH) ? flush_addr_q : pc_q;
  assign p_inst     = p_inst_q;
  assign p_pc       = p_pc_q;
  assign fetch_busy = (state_q != S_FETCH) || (imem_req && !imem_ack);

endmodule

// File: tb/tb_cpu_if_fetch.sv
// Self-checking bench for cpu_if_fetch: directed scenarios followed by random
// stalls/redirects/wait states, compared against a queue-based reference model.
module tb_cpu_if_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0000;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        cpu_stall;
  logic        c_stall;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] p_inst;
  logic [31:0] p_pc;
  logic        fetch_busy;

  int checks = 0;
  int errors = 0;

  cpu_if_fetch #(.RESET_PC(RPC), .NOP(NOP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_stall  (cpu_stall),
    .c_stall    (c_stall),
    .ex_redirect(ex_redirect),
    .ex_target  (ex_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .p_inst     (p_inst),
    .p_pc       (p_pc),
    .fetch_busy (fetch_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: word at address A is A ^ A000_0000; ack after wait_n idle cycles of req.
  int wait_n = 0;
  int wcnt   = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA000_0000;
  endfunction

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  assign imem_ack   = imem_req && (wcnt >= wait_n);
  assign imem_rdata = word_at(imem_addr);

  // Reference model: architectural PC, decode register, a 0/1-entry queue of
  // words fetched but not yet consumed, and an optional wrong-path request.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } held_t;

  held_t       m_held[$];
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_ppc;
  bit          m_squash;
  logic [31:0] m_sq_addr;

  function automatic bit m_req();
    return m_held.size() == 0;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_squash ? m_sq_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_held.delete();
    m_pc     = RPC;
    m_inst   = NOP_W;
    m_ppc    = 32'h0;
    m_squash = 1'b0;
    m_sq_addr = 32'h0;
  endtask

  task automatic model_edge();
    bit          redir, adv, ack;
    logic [31:0] a;
    redir = ex_redirect && !cpu_stall;
    adv   = !cpu_stall && !c_stall;
    ack   = imem_ack && m_req();
    a     = m_addr();
    if (m_squash) begin
      if (redir) m_pc = ex_target;
      if (adv) m_inst = NOP_W;
      if (ack) m_squash = 1'b0;
    end else if (m_held.size() != 0) begin
      if (redir) begin
        m_held.delete();
        m_pc = ex_target;
        if (!c_stall) m_inst = NOP_W;
      end else if (adv) begin
        held_t h;
        h = m_held.pop_front();
        m_inst = h.inst;
        m_ppc  = h.pc;
      end
    end else if (redir) begin
      m_pc = ex_target;
      if (!c_stall) m_inst = NOP_W;
      if (!ack) begin
        m_squash  = 1'b1;
        m_sq_addr = a;
      end
    end else if (ack) begin
      if (adv) begin
        m_inst = word_at(a);
        m_ppc  = a;
      end else begin
        m_held.push_back('{inst: word_at(a), pc: a});
      end
      m_pc = a + 32'd4;
    end else if (adv) begin
      m_inst = NOP_W;
      m_ppc  = a;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1;
    check("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    if (m_req()) check("imem_addr", imem_addr, m_addr());
    check("fetch_busy", {31'b0, fetch_busy},
          {31'b0, (m_held.size() != 0) || m_squash || (m_req() && !imem_ack)});
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("p_inst", p_inst, m_inst);
    check("p_pc", p_pc, m_ppc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_inst", p_inst, NOP_W);
    check("rst_pc", p_pc, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; cpu_stall = 1'b0; c_stall = 1'b0;
    ex_redirect = 1'b0; ex_target = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Zero-wait streaming: one instruction per edge.
    tick(); check("s1_pc0", p_pc, 32'h0); check("s1_i0", p_inst, 32'hA000_0000);
    tick(); check("s1_pc1", p_pc, 32'h4); check("s1_i1", p_inst, 32'hA000_0004);
    tick(); check("s1_pc2", p_pc, 32'h8); check("s1_i2", p_inst, 32'hA000_0008);

    // Decode stall with ack present at pc=8.
    do_reset();
    tick(); tick();
    c_stall = 1'b1;
    tick();
    #1 check("hold_req", {31'b0, imem_req}, 32'h0);
    check("hold_inst", p_inst, 32'hA000_0004);
    tick();
    c_stall = 1'b0;
    tick();
    check("hold_rel_inst", p_inst, 32'hA000_0008);
    check("hold_rel_pc", p_pc, 32'h8);
    #1 check("hold_next_addr", imem_addr, 32'hC);

    // Redirect while a 3-wait request to 0x10 is outstanding.
    tick();
    wait_n = 3;
    ex_redirect = 1'b1; ex_target = 32'h100;
    tick();
    ex_redirect = 1'b0;
    #1 check("flush_addr", imem_addr, 32'h10);
    for (int i = 0; i < 8 && m_squash; i++) tick();
    #1 check("flush_new_addr", imem_addr, 32'h100);
    for (int i = 0; i < 8 && p_inst === NOP_W; i++) tick();
    check("flush_tgt_inst", p_inst, 32'hA000_0100);
    check("flush_tgt_pc", p_pc, 32'h100);

    // Redirect with same-cycle ack on zero-wait memory.
    wait_n = 0;
    ex_redirect = 1'b1; ex_target = 32'h200;
    tick();
    ex_redirect = 1'b0;
    check("sameack_bubble", p_inst, NOP_W);
    tick();
    check("sameack_tgt", p_inst, 32'hA000_0200);

    // Global freeze for 5 cycles, ack arriving in cycle 2.
    wait_n = 1;
    cpu_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_inst", p_inst, 32'hA000_0200);
      check("frz_pc", p_pc, 32'h200);
    end
    cpu_stall = 1'b0;
    tick();
    check("frz_rel_inst", p_inst, 32'hA000_0204);
    check("frz_rel_pc", p_pc, 32'h204);

    // PC wrap at the top of the address space.
    wait_n = 0;
    ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFC;
    tick();
    ex_redirect = 1'b0;
    tick();
    check("wrap_pc", p_pc, 32'hFFFF_FFFC);
    #1 check("wrap_next_addr", imem_addr, 32'h0);

    // Reset asserted between edges while a request is waiting.
    wait_n = 4;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req", {31'b0, imem_req}, 32'h0);
    check("midrst_inst", p_inst, NOP_W);
    check("midrst_pc", p_pc, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_n = 0;
    #1 check("midrst_first_addr", imem_addr, RPC);
    tick();
    check("midrst_first_pc", p_pc, RPC);

    // Random stalls, redirects and wait states.
    for (int i = 0; i < 500; i++) begin
      if (i % 16 == 0) wait_n = int'($urandom_range(0, 3));
      c_stall     = ($urandom_range(0, 3) == 0);
      cpu_stall   = ($urandom_range(0, 6) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      r = $urandom;
      ex_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
